// File: rtl/mul_cpa_pipe_pkg.sv
// Shared multiplier definitions: default result width, low-slice width derivation
// and the handshake stage-state type used by the carry-propagate pipeline.
package mul_cpa_pipe_pkg;

    localparam int DATA_WIDTH_DEF = 22;

    function automatic int lo_width_of(input int data_width);
        return data_width / 2;
    endfunction

    typedef enum logic {
        STG_EMPTY = 1'b0,
        STG_FULL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/mul_cpa_slice.sv
// Combinational W-bit adder slice with carry-in and carry-out, the building block
// of the final carry-propagate adder behind the Wallace compressor.
module mul_cpa_slice #(
    parameter int W = 11
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] sum_o,
    output logic         co_o
);

    logic [W:0] total;

    assign total         = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
    assign {co_o, sum_o} = total;

endmodule

// File: rtl/mul_cpa_pipe.sv
// Carry-propagate adder resolving Wallace sum/carry vectors into the product.
// Define MUL_CPA_PIPE_EN for the two-stage split adder; otherwise one full-width stage.
module mul_cpa_pipe
    import mul_cpa_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LO_WIDTH   = lo_width_of(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] sout,
    input  logic [DATA_WIDTH-1:0] cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);

    // The carry vector is one place heavier than the sum vector; its top bit falls off.
    logic [DATA_WIDTH-1:0] op_b;
    logic                  cout_msb_unused;

    assign op_b            = {cout[DATA_WIDTH-2:0], 1'b0};
    assign cout_msb_unused = cout[DATA_WIDTH-1];

`ifdef MUL_CPA_PIPE_EN
    localparam int HI_WIDTH = DATA_WIDTH - LO_WIDTH;

    stage_state_e          s1_state_q, s1_state_d;
    stage_state_e          s2_state_q, s2_state_d;
    logic [LO_WIDTH-1:0]   lo_sum_q, lo_sum_d, lo_sum_c;
    logic                  lo_co_q, lo_co_d, lo_co_c;
    logic [HI_WIDTH-1:0]   hi_a_q, hi_a_d, hi_b_q, hi_b_d, hi_sum_c;
    logic                  hi_co_unused;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  s1_ready, s2_ready, accept;

    mul_cpa_slice #(.W(LO_WIDTH)) u_slice_lo (
        .a_i   (sout[LO_WIDTH-1:0]),
        .b_i   (op_b[LO_WIDTH-1:0]),
        .ci_i  (1'b0),
        .sum_o (lo_sum_c),
        .co_o  (lo_co_c)
    );

    // The registered low carry travels with its own high operands, never a neighbour's.
    mul_cpa_slice #(.W(HI_WIDTH)) u_slice_hi (
        .a_i   (hi_a_q),
        .b_i   (hi_b_q),
        .ci_i  (lo_co_q),
        .sum_o (hi_sum_c),
        .co_o  (hi_co_unused)
    );

    assign s2_ready = (s2_state_q == STG_EMPTY) || out_ready;
    assign s1_ready = (s1_state_q == STG_EMPTY) || s2_ready;
    assign in_ready = s1_ready && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_state_d = s1_state_q;
        s2_state_d = s2_state_q;
        lo_sum_d   = lo_sum_q;
        lo_co_d    = lo_co_q;
        hi_a_d     = hi_a_q;
        hi_b_d     = hi_b_q;
        result_d   = result_q;
        if (s2_ready) begin
            s2_state_d = s1_state_q;
            if (s1_state_q == STG_FULL) begin
                result_d = {hi_sum_c, lo_sum_q};
            end
        end
        if (s1_ready) begin
            s1_state_d = accept ? STG_FULL : STG_EMPTY;
        end
        if (accept) begin
            lo_sum_d = lo_sum_c;
            lo_co_d  = lo_co_c;
            hi_a_d   = sout[DATA_WIDTH-1:LO_WIDTH];
            hi_b_d   = op_b[DATA_WIDTH-1:LO_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_state_q <= STG_EMPTY;
            s2_state_q <= STG_EMPTY;
            lo_sum_q   <= '0;
            lo_co_q    <= 1'b0;
            hi_a_q     <= '0;
            hi_b_q     <= '0;
            result_q   <= '0;
        end else begin
            s1_state_q <= s1_state_d;
            s2_state_q <= s2_state_d;
            lo_sum_q   <= lo_sum_d;
            lo_co_q    <= lo_co_d;
            hi_a_q     <= hi_a_d;
            hi_b_q     <= hi_b_d;
            result_q   <= result_d;
        end
    end

    assign out_valid = (s2_state_q == STG_FULL);
    assign result    = result_q;
`else
    localparam int LO_WIDTH_UNUSED = LO_WIDTH;

    stage_state_e          out_state_q, out_state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d, sum_c;
    logic                  co_unused;
    logic                  out_stage_ready, accept;

    mul_cpa_slice #(.W(DATA_WIDTH)) u_slice_full (
        .a_i   (sout),
        .b_i   (op_b),
        .ci_i  (1'b0),
        .sum_o (sum_c),
        .co_o  (co_unused)
    );

    assign out_stage_ready = (out_state_q == STG_EMPTY) || out_ready;
    assign in_ready        = out_stage_ready && !rst;
    assign accept          = in_valid && in_ready;

    always_comb begin
        out_state_d = out_state_q;
        result_d    = result_q;
        if (out_stage_ready) begin
            out_state_d = accept ? STG_FULL : STG_EMPTY;
        end
        if (accept) begin
            result_d = sum_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_q <= STG_EMPTY;
            result_q    <= '0;
        end else begin
            out_state_q <= out_state_d;
            result_q    <= result_d;
        end
    end

    assign out_valid = (out_state_q == STG_FULL);
    assign result    = result_q;
`endif

endmodule
